// File: rtl/ac_ir_ctrl_if.sv
// Bundles the controller's register-block strobes, status inputs and memory handshake.
// master: the accumulator/IR controller.  slave: register block + memory.
interface ac_ir_ctrl_if;
    logic [2:0]  opcode;
    logic        i_flag;
    logic        o_flag;
    logic [17:0] bus_in;
    logic        mem_ack;
    logic        read_inpr_en;
    logic        write_outr_en;
    logic        read_ac_en;
    logic        write_ac_en;
    logic        read_ir_en;
    logic        write_ir_en;
    logic        in_sel;
    logic        mem_req;
    logic        mem_we;
    logic [14:0] mem_addr;

    modport master (
        input  opcode, i_flag, o_flag, bus_in, mem_ack,
        output read_inpr_en, write_outr_en, read_ac_en, write_ac_en, read_ir_en, write_ir_en,
        output in_sel, mem_req, mem_we, mem_addr
    );

    modport slave (
        output opcode, i_flag, o_flag, bus_in, mem_ack,
        input  read_inpr_en, write_outr_en, read_ac_en, write_ac_en, read_ir_en, write_ir_en,
        input  in_sel, mem_req, mem_we, mem_addr
    );
endinterface

// File: rtl/ac_ir_ctrl.sv
// Accumulator/IR sequencer: fetches 18-bit words {opcode[2:0], operand[14:0]} and drives the
// register-block strobes and memory handshake.  Optional I/O wait timeout is compiled in when
// AC_IR_CTRL_TIMEOUT_EN is defined; otherwise INW/OUTW wait indefinitely.
module ac_ir_ctrl #(
    parameter logic [14:0] PC_RESET   = 15'd0,
    parameter int unsigned IO_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    ac_ir_ctrl_if.master bus,
    output logic [14:0]  o_pc,
    output logic         o_halted,
    output logic         o_timeout_err
);

    localparam logic [3:0] StFetch = 4'd0;
    localparam logic [3:0] StOpw1  = 4'd1;
    localparam logic [3:0] StOpw2  = 4'd2;
    localparam logic [3:0] StRdir  = 4'd3;
    localparam logic [3:0] StAddr  = 4'd4;
    localparam logic [3:0] StRdac  = 4'd5;
    localparam logic [3:0] StMemrd = 4'd6;
    localparam logic [3:0] StMemwr = 4'd7;
    localparam logic [3:0] StInw   = 4'd8;
    localparam logic [3:0] StInrd  = 4'd9;
    localparam logic [3:0] StInwr  = 4'd10;
    localparam logic [3:0] StOutw  = 4'd11;
    localparam logic [3:0] StOutrd = 4'd12;
    localparam logic [3:0] StOutwr = 4'd13;
    localparam logic [3:0] StHalt  = 4'd14;

    logic [3:0]  r_state, w_state_nxt;
    logic [14:0] r_pc, w_pc_nxt;
    logic [14:0] r_operand, w_operand_nxt;
    logic        w_unused_bus;

    // Opcode bits of bus_in arrive separately on the opcode port.
    assign w_unused_bus = ^bus.bus_in[17:15];

`ifdef AC_IR_CTRL_TIMEOUT_EN
    logic [31:0] r_tmo_cnt;
    logic        r_timeout_err;
    logic        w_tmo_hit;
    logic        w_io_wait;

    assign w_tmo_hit = (r_tmo_cnt == IO_TIMEOUT - 1);
    assign w_io_wait = ((r_state == StInw) && !bus.i_flag) || ((r_state == StOutw) && !bus.o_flag);

    // Wait-cycle counter and sticky timeout flag; counter clears whenever not waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else if (w_io_wait) begin
            if (w_tmo_hit) begin
                r_tmo_cnt     <= '0;
                r_timeout_err <= 1'b1;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 32'd1;
            end
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    assign o_timeout_err = r_timeout_err;
`else
    logic w_unused_tmo;
    assign w_unused_tmo  = (IO_TIMEOUT != 0);
    assign o_timeout_err = 1'b0;
`endif

    // Sequencer state, program counter and operand latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StFetch;
            r_pc      <= PC_RESET;
            r_operand <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_operand <= w_operand_nxt;
        end
    end

    // Next-state, PC and operand update.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_operand_nxt = r_operand;
        case (r_state)
            StFetch: begin
                if (bus.mem_ack) begin
                    w_pc_nxt    = r_pc + 15'd1;
                    w_state_nxt = StOpw1;
                end
            end
            StOpw1: w_state_nxt = StOpw2;
            StOpw2: w_state_nxt = StRdir;
            StRdir: w_state_nxt = StAddr;
            StAddr: begin
                // bus_in holds the IR word read in StRdir
                w_operand_nxt = bus.bus_in[14:0];
                case (bus.opcode)
                    3'd1:    w_state_nxt = StMemrd;
                    3'd2:    w_state_nxt = StRdac;
                    3'd3:    w_state_nxt = StInw;
                    3'd4:    w_state_nxt = StOutw;
                    3'd5: begin
                        w_pc_nxt    = bus.bus_in[14:0];
                        w_state_nxt = StFetch;
                    end
                    3'd6:    w_state_nxt = StHalt;
                    default: w_state_nxt = StFetch;
                endcase
            end
            StRdac:  w_state_nxt = StMemwr;
            StMemrd: if (bus.mem_ack) w_state_nxt = StFetch;
            StMemwr: if (bus.mem_ack) w_state_nxt = StFetch;
            StInw: begin
                if (bus.i_flag) w_state_nxt = StInrd;
`ifdef AC_IR_CTRL_TIMEOUT_EN
                else if (w_tmo_hit) w_state_nxt = StFetch;
`endif
            end
            StInrd:  w_state_nxt = StInwr;
            StInwr:  w_state_nxt = StFetch;
            StOutw: begin
                if (bus.o_flag) w_state_nxt = StOutrd;
`ifdef AC_IR_CTRL_TIMEOUT_EN
                else if (w_tmo_hit) w_state_nxt = StFetch;
`endif
            end
            StOutrd: w_state_nxt = StOutwr;
            StOutwr: w_state_nxt = StFetch;
            StHalt:  w_state_nxt = StHalt;
            default: w_state_nxt = StFetch;
        endcase
    end

    // Strobe and memory decode; everything is forced low during the reset cycle.
    always_comb begin
        bus.read_inpr_en  = 1'b0;
        bus.write_outr_en = 1'b0;
        bus.read_ac_en    = 1'b0;
        bus.write_ac_en   = 1'b0;
        bus.read_ir_en    = 1'b0;
        bus.write_ir_en   = 1'b0;
        bus.in_sel        = 1'b0;
        bus.mem_req       = 1'b0;
        bus.mem_we        = 1'b0;
        bus.mem_addr      = '0;
        if (!rst) begin
            case (r_state)
                StFetch: begin
                    bus.mem_req     = 1'b1;
                    bus.mem_addr    = r_pc;
                    bus.write_ir_en = bus.mem_ack;
                end
                StRdir:  bus.read_ir_en = 1'b1;
                StRdac:  bus.read_ac_en = 1'b1;
                StMemrd: begin
                    bus.mem_req     = 1'b1;
                    bus.mem_addr    = r_operand;
                    bus.write_ac_en = bus.mem_ack;
                end
                StMemwr: begin
                    bus.mem_req  = 1'b1;
                    bus.mem_we   = 1'b1;
                    bus.mem_addr = r_operand;
                end
                StInrd:  bus.read_inpr_en = 1'b1;
                StInwr: begin
                    bus.write_ac_en = 1'b1;
                    bus.in_sel      = 1'b1;
                end
                StOutrd: bus.read_ac_en = 1'b1;
                StOutwr: begin
                    bus.write_outr_en = 1'b1;
                    bus.in_sel        = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_pc     = r_pc;
    assign o_halted = (r_state == StHalt);

endmodule

// File: tb/tb_ac_ir_ctrl.sv
// Bench for ac_ir_ctrl: emulates the register block and memory, runs directed scenarios and
// random programs checked against an instruction-level model of the machine.
module tb_ac_ir_ctrl;
    localparam logic [14:0] PC_RST = 15'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] pc;
    logic        halted;
    logic        terr;

    always #10 clk = ~clk;

    ac_ir_ctrl_if bus ();

    ac_ir_ctrl #(.PC_RESET(PC_RST), .IO_TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .o_pc          (pc),
        .o_halted      (halted),
        .o_timeout_err (terr)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [17:0] mem [0:32767];
    logic [17:0] ir, ac, outr, inpr, rdata;
    logic [17:0] out_log [$];
    logic [17:0] inp_vals [0:31];
    int          inp_idx;
    int          ack_mode  = 2;  // 0 random, 1 never, 2 always, 3 reads only
    int          flag_mode = 0;  // 0 manual, 1 random, 2 always ready

    // {read_inpr, write_outr, read_ac, write_ac, read_ir, write_ir}
    function automatic logic [5:0] strobes();
        return {bus.read_inpr_en, bus.write_outr_en, bus.read_ac_en,
                bus.write_ac_en, bus.read_ir_en, bus.write_ir_en};
    endfunction

    // Register block + memory emulation, plus per-cycle one-hot and address checks.
    initial begin
        logic [5:0]  s_str;
        logic        s_sel, s_req, s_we, s_ack;
        logic [14:0] s_addr;
        logic [17:0] s_bus, s_rd, in_data;
        bus.opcode = '0; bus.i_flag = 1'b0; bus.o_flag = 1'b0; bus.bus_in = '0;
        bus.mem_ack = 1'b0;
        ir = '0; ac = '0; outr = '0; inpr = '0; rdata = '0; inp_idx = 0;
        forever begin
            @(negedge clk); #2;
            case (ack_mode)
                0:       bus.mem_ack = bus.mem_req && ($urandom_range(0, 1) == 1);
                1:       bus.mem_ack = 1'b0;
                2:       bus.mem_ack = bus.mem_req;
                default: bus.mem_ack = bus.mem_req && !bus.mem_we;
            endcase
            rdata = mem[bus.mem_addr];
            if (flag_mode != 0) begin
                if (!bus.i_flag && (flag_mode == 2 || $urandom_range(0, 3) == 0)) begin
                    inpr = inp_vals[inp_idx % 32];
                    inp_idx++;
                    bus.i_flag = 1'b1;
                end
                if (!bus.o_flag && (flag_mode == 2 || $urandom_range(0, 3) == 0))
                    bus.o_flag = 1'b1;
            end
            #2;
            s_str = strobes(); s_sel = bus.in_sel; s_req = bus.mem_req; s_we = bus.mem_we;
            s_ack = bus.mem_ack; s_addr = bus.mem_addr; s_bus = bus.bus_in; s_rd = rdata;
            n_tests++;
            if ($countones(s_str) > 1) begin
                n_fail++;
                $display("FAIL strobe_onehot: got %b want at most one bit", s_str);
            end
            n_tests++;
            if (!s_req && s_addr !== 15'd0) begin
                n_fail++;
                $display("FAIL idle_addr: got %h want 0", s_addr);
            end
            @(posedge clk); #1;
            in_data = s_sel ? s_bus : s_rd;
            bus.opcode = ir[17:15];
            if (s_str[0]) ir = in_data;
            if (s_str[2]) ac = in_data;
            if (s_str[4]) begin
                outr = in_data;
                out_log.push_back(in_data);
                bus.o_flag = 1'b0;
            end
            if (s_str[5]) begin
                bus.bus_in = inpr;
                bus.i_flag = 1'b0;
            end
            if (s_str[3]) bus.bus_in = ac;
            if (s_str[1]) bus.bus_in = ir;
            if (s_req && s_we && s_ack) mem[s_addr] = s_bus;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cyc();
        @(negedge clk); #6;
    endtask

    // Holds rst for two edges; returns at the sample point of the first post-reset cycle.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ir = '0; ac = '0; outr = '0; inpr = '0; inp_idx = 0; out_log.delete();
        bus.bus_in = '0; bus.opcode = '0; bus.i_flag = 1'b0; bus.o_flag = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #6;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32768; i++) mem[i] = '0;
    endtask

    task automatic test_reset();
        clear_mem();
        ack_mode = 2; flag_mode = 0;
        @(negedge clk); rst = 1'b1; #6;
        n_tests++;
        if ({strobes(), bus.mem_req, bus.mem_we} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0", {strobes(), bus.mem_req, bus.mem_we});
        end
        next_cyc();
        n_tests++;
        if (pc !== PC_RST) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, PC_RST); end
        n_tests++;
        if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_tests++;
        if (terr !== 1'b0) begin n_fail++; $display("FAIL reset_terr: got %b want 0", terr); end
    endtask

    task automatic test_lda();
        logic [5:0]  exp_str [0:5];
        logic [17:0] data;
        clear_mem();
        data = 18'($urandom);
        mem[0] = {3'd1, 15'd5};
        mem[1] = {3'd6, 15'd0};
        mem[5] = data;
        exp_str = '{6'h01, 6'h00, 6'h00, 6'h02, 6'h00, 6'h04};
        ack_mode = 2; flag_mode = 0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) next_cyc();
            n_tests++;
            if (strobes() !== exp_str[c]) begin
                n_fail++;
                $display("FAIL lda_strobe_c%0d: got %b want %b", c + 1, strobes(), exp_str[c]);
            end
            if (c == 1) begin
                n_tests++;
                if (pc !== 15'd1) begin n_fail++; $display("FAIL lda_pc: got %h want 1", pc); end
            end
        end
        n_tests++;
        if (bus.mem_addr !== 15'd5) begin
            n_fail++; $display("FAIL lda_addr: got %h want 5", bus.mem_addr);
        end
        next_cyc();
        n_tests++;
        if (ac !== data) begin n_fail++; $display("FAIL lda_ac: got %h want %h", ac, data); end
        n_tests++;
        if (bus.mem_addr !== 15'd1 || bus.mem_req !== 1'b1) begin
            n_fail++; $display("FAIL lda_next_fetch: got %h want 1", bus.mem_addr);
        end
    endtask

    task automatic test_out();
        logic [17:0] val;
        int          bad;
        clear_mem();
        mem[0] = {3'd4, 15'($urandom)};
        mem[1] = {3'd6, 15'd0};
        ack_mode = 2; flag_mode = 0;
        do_reset();
        val = 18'($urandom);
        ac  = val;
        for (int i = 0; i < 5; i++) next_cyc();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) next_cyc();
            if (strobes() !== 6'h00 || bus.mem_req !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL out_wait_quiet: got %0d busy cycles want 0", bad); end
        @(negedge clk); bus.o_flag = 1'b1; #6;
        next_cyc();
        n_tests++;
        if (strobes() !== 6'h08) begin
            n_fail++; $display("FAIL out_read_ac: got %b want 001000", strobes());
        end
        next_cyc();
        n_tests++;
        if (strobes() !== 6'h10 || bus.in_sel !== 1'b1) begin
            n_fail++; $display("FAIL out_write_outr: got %b sel %b want 010000 sel 1", strobes(), bus.in_sel);
        end
        next_cyc();
        n_tests++;
        if (outr !== val || out_log.size() != 1) begin
            n_fail++; $display("FAIL out_value: got %h want %h", outr, val);
        end
    endtask

    task automatic test_jmp_wrap();
        logic [14:0] fetches [$];
        clear_mem();
        mem[0]        = {3'd5, 15'h7FFF};
        mem[15'h7FFF] = {3'd0, 15'd0};
        ack_mode = 2; flag_mode = 0;
        do_reset();
        for (int c = 0; c < 40 && fetches.size() < 3; c++) begin
            if (c > 0) next_cyc();
            if (bus.write_ir_en === 1'b1) fetches.push_back(bus.mem_addr);
        end
        n_tests++;
        if (fetches.size() != 3) begin
            n_fail++; $display("FAIL jmp_fetch_count: got %0d want 3", fetches.size());
        end else begin
            n_tests++;
            if (fetches[1] !== 15'h7FFF) begin
                n_fail++; $display("FAIL jmp_target: got %h want 7fff", fetches[1]);
            end
            n_tests++;
            if (fetches[2] !== 15'h0000) begin
                n_fail++; $display("FAIL jmp_wrap: got %h want 0000", fetches[2]);
            end
        end
    endtask

    task automatic test_reset_midwrite();
        logic [17:0] orig;
        int          c;
        int          bad;
        clear_mem();
        orig    = 18'($urandom);
        mem[0]  = {3'd2, 15'd10};
        mem[10] = orig;
        ack_mode = 3; flag_mode = 0;
        do_reset();
        c = 0;
        while (bus.mem_we !== 1'b1 && c < 20) begin next_cyc(); c++; end
        n_tests++;
        if (bus.mem_we !== 1'b1) begin
            n_fail++; $display("FAIL sta_reach_memwr: got %b want 1", bus.mem_we);
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 15'd10) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL sta_hold: got %0d unstable cycles want 0", bad); end
        @(negedge clk); rst = 1'b1; #6;
        n_tests++;
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin
            n_fail++; $display("FAIL rst_drop: got req %b we %b want 0 0", bus.mem_req, bus.mem_we);
        end
        @(negedge clk); rst = 1'b0; #6;
        n_tests++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== PC_RST || pc !== PC_RST) begin
            n_fail++;
            $display("FAIL rst_refetch: got req %b we %b addr %h pc %h want 1 0 %h %h",
                     bus.mem_req, bus.mem_we, bus.mem_addr, pc, PC_RST, PC_RST);
        end
        n_tests++;
        if (mem[10] !== orig) begin n_fail++; $display("FAIL sta_no_write: got %h want %h", mem[10], orig); end
    endtask

    task automatic test_io_wait();
        int bad;
        clear_mem();
        mem[0] = {3'd3, 15'd0};
        mem[1] = {3'd6, 15'd0};
        ack_mode = 2; flag_mode = 0;
        do_reset();
        for (int i = 0; i < 5; i++) next_cyc();
        bad = 0;
`ifdef AC_IR_CTRL_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cyc();
            if (strobes() !== 6'h00 || bus.mem_req !== 1'b0 || terr !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL tmo_wait: got %0d bad cycles want 0", bad); end
        next_cyc();
        n_tests++;
        if (terr !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b want 1", terr); end
        n_tests++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 15'd1) begin
            n_fail++; $display("FAIL tmo_fetch: got req %b addr %h want 1 0001", bus.mem_req, bus.mem_addr);
        end
        next_cyc();
        next_cyc();
        n_tests++;
        if (terr !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", terr); end
`else
        for (int i = 0; i < 50; i++) begin
            if (i > 0) next_cyc();
            if (strobes() !== 6'h00 || bus.mem_req !== 1'b0 || terr !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL inp_wait: got %0d bad cycles want 0", bad); end
        @(negedge clk); inpr = 18'($urandom); bus.i_flag = 1'b1; #6;
        next_cyc();
        n_tests++;
        if (strobes() !== 6'h20) begin n_fail++; $display("FAIL inp_read: got %b want 100000", strobes()); end
        next_cyc();
        n_tests++;
        if (strobes() !== 6'h04 || bus.in_sel !== 1'b1) begin
            n_fail++; $display("FAIL inp_write_ac: got %b sel %b want 000100 sel 1", strobes(), bus.in_sel);
        end
        next_cyc();
        n_tests++;
        if (ac !== inpr) begin n_fail++; $display("FAIL inp_value: got %h want %h", ac, inpr); end
`endif
    endtask

    task automatic test_halt();
        int bad;
        clear_mem();
        mem[0] = {3'd6, 15'd0};
        ack_mode = 2; flag_mode = 0;
        do_reset();
        for (int i = 0; i < 5; i++) next_cyc();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) next_cyc();
            if (halted !== 1'b1 || bus.mem_req !== 1'b0 || strobes() !== 6'h00) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL halt_hold: got %0d bad cycles want 0", bad); end
        n_tests++;
        if (pc !== 15'd1) begin n_fail++; $display("FAIL halt_pc: got %h want 1", pc); end
    endtask

    // Random programs: 20 random instructions then HLT; JMPs only go forward.
    task automatic test_random_programs();
        logic [17:0] mm [0:127];
        logic [17:0] exp_out [$];
        logic [17:0] w, ac_m;
        logic [14:0] pc_m;
        int          op, idx, steps, c, bad;
        bit          halt_m;
        for (int t = 0; t < 4; t++) begin
            clear_mem();
            for (int i = 0; i < 20; i++) begin
                op = int'($urandom_range(0, 7));
                if (op == 6) op = 0;
                if (op == 1 || op == 2) w = {3'(op), 15'(64 + $urandom_range(0, 15))};
                else if (op == 5) w = {3'd5, 15'((i + $urandom_range(1, 3)) > 20 ? 20 : (i + $urandom_range(1, 3)))};
                else w = {3'(op), 15'($urandom)};
                mem[i] = w;
            end
            mem[20] = {3'd6, 15'd0};
            for (int i = 64; i < 80; i++) mem[i] = 18'($urandom);
            for (int i = 0; i < 32; i++) inp_vals[i] = 18'($urandom);
            for (int i = 0; i < 128; i++) mm[i] = mem[i];
            // instruction-level reference execution
            pc_m = 15'd0; ac_m = '0; idx = 0; halt_m = 0; steps = 0; exp_out.delete();
            while (!halt_m && steps < 100) begin
                w = mm[pc_m[6:0]];
                pc_m = pc_m + 15'd1;
                case (w[17:15])
                    3'd1: ac_m = mm[w[6:0]];
                    3'd2: mm[w[6:0]] = ac_m;
                    3'd3: begin ac_m = inp_vals[idx % 32]; idx++; end
                    3'd4: exp_out.push_back(ac_m);
                    3'd5: pc_m = w[14:0];
                    3'd6: halt_m = 1;
                    default: ;
                endcase
                steps++;
            end
            ack_mode = 0;
`ifdef AC_IR_CTRL_TIMEOUT_EN
            flag_mode = 2;
`else
            flag_mode = 1;
`endif
            do_reset();
            c = 0;
            while (halted !== 1'b1 && c < 4000) begin next_cyc(); c++; end
            n_tests++;
            if (halted !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_halt: got %b want 1", t, halted); end
            n_tests++;
            if (pc !== pc_m) begin n_fail++; $display("FAIL rnd%0d_pc: got %h want %h", t, pc, pc_m); end
            n_tests++;
            if (ac !== ac_m) begin n_fail++; $display("FAIL rnd%0d_ac: got %h want %h", t, ac, ac_m); end
            bad = 0;
            for (int i = 64; i < 80; i++) if (mem[i] !== mm[i]) bad++;
            n_tests++;
            if (bad != 0) begin n_fail++; $display("FAIL rnd%0d_mem: got %0d differing words want 0", t, bad); end
            bad = (out_log.size() != exp_out.size()) ? 1 : 0;
            if (bad == 0) for (int i = 0; i < exp_out.size(); i++) if (out_log[i] !== exp_out[i]) bad++;
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL rnd%0d_out: got %0d outputs want %0d (%0d differ)",
                         t, out_log.size(), exp_out.size(), bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_out();
        test_jmp_wrap();
        test_reset_midwrite();
        test_io_wait();
        test_halt();
        test_random_programs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ac_ir_ctrl.md
AC_IR_CTRL -- requirements
Module: ac_ir_ctrl

Interface
REQ-001 Parameter PC_RESET, default 15'd0: program counter value loaded on reset.
REQ-002 Parameter IO_TIMEOUT, default 255: I/O wait limit in cycles, used only when AC_IR_CTRL_TIMEOUT_EN is defined.
REQ-003 clk  in  1  clock; all logic on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 opcode  in  3  register-block opcode; lags IR by 1 cycle.
REQ-006 I_flag / O_flag  in  1 each  input-ready / output-empty flags from the register block.
REQ-007 bus_in  in  18  register-block out_data, valid 1 cycle after a read enable.
REQ-008 mem_ack  in  1  memory acknowledge; read data valid while high.
REQ-009 read_inpr_en, write_outr_en, read_ac_en, write_ac_en, read_ir_en, write_ir_en  out  1 each  register-block strobes.
REQ-010 in_sel  out  1  in_data source: 0 = memory data, 1 = bus_in loopback.
REQ-011 mem_req, mem_we  out  1 each  memory request and write qualifier.
REQ-012 mem_addr  out  15  memory address; pc  out  15  program counter.
REQ-013 halted  out  1  HLT executed; timeout_err  out  1  sticky I/O timeout flag.

Function
REQ-014 At most one of the six strobes SHALL be high in any cycle; all strobes are registered-free combinational decodes of state.
REQ-015 States: FETCH, OPW1, OPW2, RDIR, ADDR, RDAC, MEMRD, MEMWR, INW, INRD, INWR, OUTW, OUTRD, OUTWR, HALT.
REQ-016 FETCH: mem_req=1, mem_we=0, mem_addr=pc, in_sel=0; write_ir_en=mem_ack; on mem_ack pc<=pc+1 (wraps 7FFF->0000), go OPW1.
REQ-017 OPW1 -> OPW2 -> RDIR unconditionally (2 cycles for IR write plus opcode register).
REQ-018 RDIR: read_ir_en=1 -> ADDR; ADDR: operand<=bus_in[14:0], dispatch on opcode.
REQ-019 Opcode 0 NOP and 7 (reserved): -> FETCH.
REQ-020 Opcode 1 LDA: MEMRD mem_req=1, mem_addr=operand, in_sel=0, write_ac_en=mem_ack; on ack -> FETCH.
REQ-021 Opcode 2 STA: RDAC read_ac_en=1 -> MEMWR mem_req=1, mem_we=1, mem_addr=operand until mem_ack -> FETCH.
REQ-022 Opcode 3 INP: INW waits for I_flag=1; INRD read_inpr_en=1; INWR write_ac_en=1, in_sel=1 -> FETCH.
REQ-023 Opcode 4 OUT: OUTW waits for O_flag=1; OUTRD read_ac_en=1; OUTWR write_outr_en=1, in_sel=1 -> FETCH.
REQ-024 Opcode 5 JMP: pc<=operand -> FETCH.
REQ-025 Opcode 6 HLT: -> HALT; halted=1, all strobes and mem_req low until rst.
REQ-026 mem_req SHALL stay high with stable mem_addr/mem_we until mem_ack; unbounded wait permitted.
REQ-027 mem_addr SHALL be 0 in states without mem_req; in_sel 0 unless stated.

Reset
REQ-028 rst at any cycle, including mid-handshake: next state FETCH, pc=PC_RESET, operand=0, halted=0, timeout_err=0, timeout counter=0.
REQ-029 During rst cycle all strobes, mem_req, mem_we SHALL be 0.

Configuration
REQ-030 Macro AC_IR_CTRL_TIMEOUT_EN defined: counter runs in INW/OUTW; on reaching IO_TIMEOUT cycles without flag, timeout_err<=1 (sticky) and -> FETCH skipping the transfer; counter clears on leaving INW/OUTW.
REQ-031 Macro undefined: INW/OUTW wait indefinitely; timeout_err tied 0; no counter logic.

Verification
REQ-032 Reset, mem word 0 = {3'd1,15'd5}, word 5 ready: FETCH ack at cycle 1, write_ir_en cycle 1, read_ir_en cycle 4, write_ac_en with mem_addr=5 on ack; pc=1.
REQ-033 OUT with O_flag=0 for 10 cycles then 1: no strobes during wait; read_ac_en then write_outr_en, in_sel=1, consecutive cycles.
REQ-034 JMP 15'h7FFF then NOP at 7FFF: next fetch at 7FFF, following fetch at 0000 (wrap).
REQ-035 rst asserted while MEMWR waits for ack: mem_req/mem_we drop next cycle, FETCH at PC_RESET.
REQ-036 With AC_IR_CTRL_TIMEOUT_EN, IO_TIMEOUT=4, INP and I_flag=0: timeout_err=1 after 4 cycles, no write_ac_en, next FETCH; without macro, waits forever.
REQ-037 HLT: halted=1, mem_req=0 for 100 cycles; strobe one-hot assertion checked throughout all tests.
